// File: rtl/rs485_pkg.sv
// Shared constants and state encodings for the RS485 PSLV poll master and the slave-side detector.
package rs485_pkg;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   DATA_BITS  = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_TX_FRAME, S_TURN, S_RX_WAIT, S_RX_BITS, S_RX_STOP, S_DONE
  } poll_state_t;

  typedef enum logic [1:0] {RXP_HUNT, RXP_CONFIRM, RXP_DATA, RXP_STOP} rx_phase_t;

  typedef enum logic [1:0] {RES_OK, RES_TIMEOUT, RES_FRAME} poll_result_t;

  // Width of a counter that must hold max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/rs485_rx_byte.sv
// UART-style byte receiver: start confirm at mid-bit, LSB-first shift, stop check.
// Status outputs are combinational strobes in the cycle the deciding sample is taken.
module rs485_rx_byte
  import rs485_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 rx,
  output logic                 start_ok,
  output logic                 last_bit,
  output logic                 byte_valid,
  output logic                 stop_err,
  output logic                 false_start,
  output logic [DATA_BITS-1:0] byte_data
);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = cnt_width(CLKS_PER_BIT - 1);
  localparam int BW   = cnt_width(DATA_BITS - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'((HALF > 0) ? HALF - 1 : 0);

  rx_phase_t            phase, phase_next;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] sr;
  logic                 tick;

  assign tick      = (cnt == '0);
  assign byte_data = sr;

  always_comb begin
    phase_next  = phase;
    start_ok    = 1'b0;
    last_bit    = 1'b0;
    byte_valid  = 1'b0;
    stop_err    = 1'b0;
    false_start = 1'b0;
    if (!enable) begin
      phase_next = RXP_HUNT;
    end else begin
      case (phase)
        RXP_HUNT:
          if (rx == START_BIT) begin
            // With no half-bit delay the start is confirmed on first sight.
            if (HALF == 0) begin
              start_ok   = 1'b1;
              phase_next = RXP_DATA;
            end else begin
              phase_next = RXP_CONFIRM;
            end
          end
        RXP_CONFIRM:
          if (tick) begin
            if (rx == START_BIT) begin
              start_ok   = 1'b1;
              phase_next = RXP_DATA;
            end else begin
              false_start = 1'b1;
              phase_next  = RXP_HUNT;
            end
          end
        RXP_DATA:
          if (tick && bit_cnt == '0) begin
            last_bit   = 1'b1;
            phase_next = RXP_STOP;
          end
        RXP_STOP:
          if (tick) begin
            if (rx == STOP_BIT) byte_valid = 1'b1;
            else                stop_err   = 1'b1;
            phase_next = RXP_HUNT;
          end
        default: phase_next = RXP_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= RXP_HUNT;
      cnt     <= '0;
      bit_cnt <= '0;
      sr      <= '0;
    end else begin
      phase <= phase_next;
      if (phase == RXP_HUNT && phase_next == RXP_CONFIRM) begin
        cnt <= HALF_LOAD;
      end else if (start_ok) begin
        cnt     <= BIT_LOAD;
        bit_cnt <= BW'(DATA_BITS - 1);
      end else if (phase == RXP_DATA || phase == RXP_STOP) begin
        if (tick) begin
          cnt <= BIT_LOAD;
          if (phase == RXP_DATA) begin
            sr <= {rx, sr[DATA_BITS-1:1]};
            if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
          end
        end else begin
          cnt <= cnt - 1'b1;
        end
      end else if (phase == RXP_CONFIRM && !tick) begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/rs485_poll_master.sv
// RS485 PSLV poll initiator: sends an address byte, turns the bus around, collects a 16-bit reply.
// IDLE wait poll | TX_FRAME drive frame | TURN bus release | RX_WAIT hunt start | RX_BITS data | RX_STOP stop | DONE report
module rs485_poll_master
  import rs485_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 2,
  parameter int TURN_CYCLES  = 2,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        poll_start,
  input  logic [7:0]  slave_addr,
  input  logic        rx,
  output logic        tx,
  output logic        tx_en,
  output logic        busy,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        timeout_err,
  output logic        frame_err
);
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;
  localparam int CW = cnt_width(CLKS_PER_BIT - 1);
  localparam int FW = cnt_width(FRAME_BITS - 1);
  localparam int TW = cnt_width(TURN_CYCLES - 1);
  localparam int WW = cnt_width(RESP_TIMEOUT - 1);

  poll_state_t          state, state_next;
  poll_result_t         result, result_next;
  logic [FRAME_BITS-1:0] tx_sr;
  logic [CW-1:0]        bit_clk;
  logic [FW-1:0]        bits_left;
  logic [TW-1:0]        turn_cnt;
  logic [WW-1:0]        wait_cnt;
  logic                 byte_idx;
  logic [7:0]           first_byte;
  logic                 tx_last, rx_enable;
  logic                 start_ok, last_bit, byte_valid, stop_err, false_start;
  logic [7:0]           byte_data;

  assign tx_last   = (bit_clk == '0) && (bits_left == '0);
  assign rx_enable = (state == S_RX_WAIT) || (state == S_RX_BITS) || (state == S_RX_STOP);

  rs485_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .rst(rst), .enable(rx_enable), .rx(rx),
    .start_ok(start_ok), .last_bit(last_bit), .byte_valid(byte_valid),
    .stop_err(stop_err), .false_start(false_start), .byte_data(byte_data)
  );

  always_comb begin
    state_next  = state;
    result_next = result;
    case (state)
      S_IDLE:     if (poll_start) state_next = S_TX_FRAME;
      S_TX_FRAME: if (tx_last) state_next = S_TURN;
      S_TURN:     if (turn_cnt == '0) state_next = S_RX_WAIT;
      S_RX_WAIT:
        if (start_ok) begin
          state_next = S_RX_BITS;
        end else if (false_start) begin
          result_next = RES_FRAME;
          state_next  = S_DONE;
        end else if (wait_cnt == WW'(RESP_TIMEOUT - 1)) begin
          result_next = RES_TIMEOUT;
          state_next  = S_DONE;
        end
      S_RX_BITS:  if (last_bit) state_next = S_RX_STOP;
      S_RX_STOP:
        if (stop_err) begin
          result_next = RES_FRAME;
          state_next  = S_DONE;
        end else if (byte_valid) begin
          if (byte_idx) begin
            result_next = RES_OK;
            state_next  = S_DONE;
          end else begin
            state_next = S_RX_WAIT;
          end
        end
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      result     <= RES_OK;
      tx_sr      <= '1;
      bit_clk    <= '0;
      bits_left  <= '0;
      turn_cnt   <= '0;
      wait_cnt   <= '0;
      byte_idx   <= 1'b0;
      first_byte <= '0;
      resp_data  <= '0;
    end else begin
      state  <= state_next;
      result <= result_next;
      case (state)
        S_IDLE:
          if (poll_start) begin
            tx_sr     <= {{STOP_BITS{STOP_BIT}}, slave_addr, START_BIT};
            bit_clk   <= CW'(CLKS_PER_BIT - 1);
            bits_left <= FW'(FRAME_BITS - 1);
          end
        S_TX_FRAME:
          if (bit_clk == '0) begin
            bit_clk <= CW'(CLKS_PER_BIT - 1);
            tx_sr   <= {IDLE_LEVEL, tx_sr[FRAME_BITS-1:1]};
            if (bits_left != '0) bits_left <= bits_left - 1'b1;
            if (tx_last) turn_cnt <= TW'(TURN_CYCLES - 1);
          end else begin
            bit_clk <= bit_clk - 1'b1;
          end
        S_TURN: begin
          if (turn_cnt != '0) turn_cnt <= turn_cnt - 1'b1;
          wait_cnt <= '0;
          byte_idx <= 1'b0;
        end
        S_RX_WAIT:
          if (state_next == S_RX_WAIT) wait_cnt <= wait_cnt + 1'b1;
        S_RX_STOP:
          // Data is only committed once both bytes framed correctly.
          if (byte_valid) begin
            if (!byte_idx) begin
              first_byte <= byte_data;
              byte_idx   <= 1'b1;
              wait_cnt   <= '0;
            end else begin
              resp_data <= {first_byte, byte_data};
            end
          end
        default: ;
      endcase
    end
  end

  assign tx          = (state == S_TX_FRAME) ? tx_sr[0] : IDLE_LEVEL;
  assign tx_en       = (state == S_TX_FRAME);
  assign busy        = (state != S_IDLE);
  assign resp_valid  = (state == S_DONE) && (result == RES_OK);
  assign timeout_err = (state == S_DONE) && (result == RES_TIMEOUT);
  assign frame_err   = (state == S_DONE) && (result == RES_FRAME);
endmodule

// File: tb/tb_rs485_poll_master.sv
// Bench for rs485_poll_master: one instance at 1 clk/bit, one at 4 clks/bit, model slave on rx.
module tb_rs485_poll_master;
  localparam int K_NONE = 0, K_OK = 1, K_TO = 2, K_FE = 3, K_MULTI = 4;

  typedef struct {
    int          kind;
    logic [15:0] data;
  } exp_t;

  logic clk, rst;
  logic poll_a, rx_a, tx_a, txen_a, busy_a, rv_a, to_a, fe_a;
  logic poll_b, rx_b, tx_b, txen_b, busy_b, rv_b, to_b, fe_b;
  logic [7:0]  addr_a, addr_b;
  logic [15:0] rd_a, rd_b;

  int   total = 0;
  int   passed = 0;
  exp_t sb[$];

  rs485_poll_master #(.CLKS_PER_BIT(1), .STOP_BITS(2), .TURN_CYCLES(2), .RESP_TIMEOUT(64)) dut_a (
    .clk(clk), .rst(rst), .poll_start(poll_a), .slave_addr(addr_a), .rx(rx_a),
    .tx(tx_a), .tx_en(txen_a), .busy(busy_a), .resp_valid(rv_a), .resp_data(rd_a),
    .timeout_err(to_a), .frame_err(fe_a)
  );

  rs485_poll_master #(.CLKS_PER_BIT(4), .STOP_BITS(2), .TURN_CYCLES(2), .RESP_TIMEOUT(64)) dut_b (
    .clk(clk), .rst(rst), .poll_start(poll_b), .slave_addr(addr_b), .rx(rx_b),
    .tx(tx_b), .tx_en(txen_b), .busy(busy_b), .resp_valid(rv_b), .resp_data(rd_b),
    .timeout_err(to_b), .frame_err(fe_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic frame_bit(input logic [7:0] a, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return a[k-1];
    return 1'b1;
  endfunction

  // Leaves the bench at cycle 1 of the poll (poll_start was high in cycle 0).
  task automatic start_poll(input int which, input logic [7:0] a);
    if (which == 0) begin poll_a = 1'b1; addr_a = a; end
    else            begin poll_b = 1'b1; addr_b = a; end
    step();
    poll_a = 1'b0;
    poll_b = 1'b0;
  endtask

  task automatic send_byte(input int which, input logic [7:0] d, input logic stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (which == 0) rx_a = fr[i]; else rx_b = fr[i];
      repeat ((which == 0) ? 1 : 4) step();
    end
    if (which == 0) rx_a = 1'b1; else rx_b = 1'b1;
  endtask

  // Observes (does not judge) the first outcome pulse within a cycle budget.
  task automatic wait_pulse(input int which, input int budget, output int kind,
                            output logic [15:0] data, output int n);
    logic v, t, f;
    kind = K_NONE;
    data = '0;
    n    = budget;
    for (int i = 0; i < budget; i++) begin
      v    = (which == 0) ? rv_a : rv_b;
      t    = (which == 0) ? to_a : to_b;
      f    = (which == 0) ? fe_a : fe_b;
      data = (which == 0) ? rd_a : rd_b;
      if (v || t || f) begin
        n = i;
        if (int'(v) + int'(t) + int'(f) > 1) kind = K_MULTI;
        else if (v) kind = K_OK;
        else if (t) kind = K_TO;
        else        kind = K_FE;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if ({tx_a, txen_a, busy_a, rv_a, to_a, fe_a} !== 6'b100000)
      $display("FAIL reset_ctl_a: got %b want 100000", {tx_a, txen_a, busy_a, rv_a, to_a, fe_a});
    else passed++;
    total++;
    if (rd_a !== 16'h0000) $display("FAIL reset_data_a: got %h want 0000", rd_a); else passed++;
    total++;
    if ({tx_b, txen_b, busy_b, rv_b, to_b, fe_b} !== 6'b100000)
      $display("FAIL reset_ctl_b: got %b want 100000", {tx_b, txen_b, busy_b, rv_b, to_b, fe_b});
    else passed++;
    total++;
    if (rd_b !== 16'h0000) $display("FAIL reset_data_b: got %h want 0000", rd_b); else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_tx_and_reply();
    int kind, n;
    logic [15:0] data;
    exp_t e;
    start_poll(0, 8'h01);
    for (int c = 1; c <= 12; c++) begin
      total++;
      if (c <= 11 && tx_a !== frame_bit(8'h01, c - 1))
        $display("FAIL tx_bit c%0d: got %b want %b", c, tx_a, frame_bit(8'h01, c - 1));
      else if (c == 12 && tx_a !== 1'b1) $display("FAIL tx_idle c12: got %b want 1", tx_a);
      else passed++;
      total++;
      if (txen_a !== (c <= 11)) $display("FAIL tx_en c%0d: got %b want %b", c, txen_a, c <= 11);
      else passed++;
      step();
    end
    sb.push_back('{K_OK, 16'h3FE0});
    fork
      begin repeat (3) step(); send_byte(0, 8'h3F, 1'b1); send_byte(0, 8'hE0, 1'b1); end
      wait_pulse(0, 300, kind, data, n);
    join
    e = sb.pop_front();
    total++;
    if (kind !== e.kind) $display("FAIL reply_kind: got %0d want %0d", kind, e.kind); else passed++;
    total++;
    if (data !== e.data) $display("FAIL reply_data: got %h want %h", data, e.data); else passed++;
    step();
    total++;
    if (busy_a !== 1'b0) $display("FAIL reply_busy_after: got %b want 0", busy_a); else passed++;
  endtask

  task automatic test_timeout();
    int kind, n;
    logic [15:0] data;
    exp_t e;
    start_poll(0, 8'h07);
    sb.push_back('{K_TO, 16'h3FE0});
    wait_pulse(0, 300, kind, data, n);
    e = sb.pop_front();
    total++;
    if (kind !== e.kind) $display("FAIL timeout_kind: got %0d want %0d", kind, e.kind); else passed++;
    total++;
    if (1 + n !== 78) $display("FAIL timeout_cycle: got %0d want 78", 1 + n); else passed++;
    total++;
    if (data !== e.data) $display("FAIL timeout_data: got %h want %h", data, e.data); else passed++;
    step();
  endtask

  task automatic test_frame_err();
    int kind, n;
    logic [15:0] data;
    exp_t e;
    start_poll(0, 8'h22);
    sb.push_back('{K_FE, 16'h3FE0});
    fork
      begin repeat (15) step(); send_byte(0, 8'h12, 1'b1); send_byte(0, 8'h34, 1'b0); end
      wait_pulse(0, 300, kind, data, n);
    join
    e = sb.pop_front();
    total++;
    if (kind !== e.kind) $display("FAIL stoperr_kind: got %0d want %0d", kind, e.kind); else passed++;
    total++;
    if (data !== e.data) $display("FAIL stoperr_data: got %h want %h", data, e.data); else passed++;
    step();
  endtask

  task automatic test_ignore_and_reset();
    int kind, n;
    logic [15:0] data;
    exp_t e;
    start_poll(0, 8'hC3);
    repeat (4) step();
    poll_a = 1'b1;
    addr_a = 8'hFF;
    step();
    poll_a = 1'b0;
    for (int c = 6; c <= 11; c++) begin
      total++;
      if (tx_a !== frame_bit(8'hC3, c - 1))
        $display("FAIL ignore_tx c%0d: got %b want %b", c, tx_a, frame_bit(8'hC3, c - 1));
      else passed++;
      step();
    end
    repeat (4) step();
    rx_a = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin rx_a = i[0]; step(); end
    rst = 1'b1;
    step();
    rst  = 1'b0;
    rx_a = 1'b1;
    total++;
    if ({tx_a, txen_a, busy_a, rv_a, to_a, fe_a} !== 6'b100000)
      $display("FAIL midreset_ctl: got %b want 100000", {tx_a, txen_a, busy_a, rv_a, to_a, fe_a});
    else passed++;
    total++;
    if (rd_a !== 16'h0000) $display("FAIL midreset_data: got %h want 0000", rd_a); else passed++;
    repeat (3) step();
    total++;
    if (busy_a !== 1'b0) $display("FAIL no_queue: got %b want 0", busy_a); else passed++;
    start_poll(0, 8'h02);
    sb.push_back('{K_OK, 16'h55AA});
    fork
      begin repeat (15) step(); send_byte(0, 8'h55, 1'b1); send_byte(0, 8'hAA, 1'b1); end
      wait_pulse(0, 300, kind, data, n);
    join
    e = sb.pop_front();
    total++;
    if (kind !== e.kind) $display("FAIL repoll_kind: got %0d want %0d", kind, e.kind); else passed++;
    total++;
    if (data !== e.data) $display("FAIL repoll_data: got %h want %h", data, e.data); else passed++;
    step();
  endtask

  task automatic test_clk4();
    int kind, n;
    logic [15:0] data;
    exp_t e;
    start_poll(1, 8'h5A);
    sb.push_back('{K_FE, 16'h0000});
    repeat (49) step();
    rx_b = 1'b0;
    step();
    rx_b = 1'b1;
    wait_pulse(1, 300, kind, data, n);
    e = sb.pop_front();
    total++;
    if (kind !== e.kind) $display("FAIL glitch_kind: got %0d want %0d", kind, e.kind); else passed++;
    total++;
    if (data !== e.data) $display("FAIL glitch_data: got %h want %h", data, e.data); else passed++;
    step();
    start_poll(1, 8'h5A);
    sb.push_back('{K_OK, 16'hA55A});
    fork
      begin repeat (50) step(); send_byte(1, 8'hA5, 1'b1); send_byte(1, 8'h5A, 1'b1); end
      wait_pulse(1, 400, kind, data, n);
    join
    e = sb.pop_front();
    total++;
    if (kind !== e.kind) $display("FAIL clk4_kind: got %0d want %0d", kind, e.kind); else passed++;
    total++;
    if (data !== e.data) $display("FAIL clk4_data: got %h want %h", data, e.data); else passed++;
    step();
    total++;
    if (busy_b !== 1'b0) $display("FAIL clk4_busy_after: got %b want 0", busy_b); else passed++;
  endtask

  initial begin
    rst    = 1'b1;
    poll_a = 1'b0; addr_a = 8'h00; rx_a = 1'b1;
    poll_b = 1'b0; addr_b = 8'h00; rx_b = 1'b1;
    test_reset();
    test_tx_and_reply();
    test_timeout();
    test_frame_err();
    test_ignore_and_reset();
    test_clk4();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
